// File: rtl/seg_mux_capture_if.sv
// Bus bundle for the multiplexed 7-segment capture block: pin-side inputs plus
// the decoded frame and status outputs.
interface seg_mux_capture_if;
    logic [6:0]  seven_seg;
    logic [3:0]  digit_en;
    logic        clr_err;
    logic [15:0] value;
    logic        frame_valid;
    logic        seg_err;
    logic        en_err;

    modport master (
        output seven_seg, digit_en, clr_err,
        input  value, frame_valid, seg_err, en_err
    );

    modport slave (
        input  seven_seg, digit_en, clr_err,
        output value, frame_valid, seg_err, en_err
    );
endinterface

// File: rtl/seg_mux_capture.sv
// Receives a scanned 7-segment display, filters scan transitions and ghosting,
// decodes each stable digit and publishes complete 4-digit frames.
module seg_mux_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          EN_ACTIVE_LOW  = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    seg_mux_capture_if.slave bus
);

    localparam logic [7:0] CntMax  = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SegFlip = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] EnFlip  = {4{EN_ACTIVE_LOW}};

    // Returns {unrecognised, code}.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h7E:   res = {1'b0, 4'h0};
            7'h30:   res = {1'b0, 4'h1};
            7'h6D:   res = {1'b0, 4'h2};
            7'h79:   res = {1'b0, 4'h3};
            7'h33:   res = {1'b0, 4'h4};
            7'h5B:   res = {1'b0, 4'h5};
            7'h5F:   res = {1'b0, 4'h6};
            7'h70:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h7B:   res = {1'b0, 4'h9};
            7'h00:   res = {1'b0, 4'hE};
            default: res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    logic [10:0]      sync1_q, sync2_q;
    logic [10:0]      samp_prev_q;
    logic [10:0]      samp;
    logic [6:0]       samp_seg;
    logic [3:0]       samp_en;
    logic [7:0]       cnt_q, cnt_d;
    logic             accepted_q, accepted_d;
    logic             changed;
    logic             accept;
    logic             en_one;
    logic             en_multi;
    logic [1:0]       en_idx;
    logic [4:0]       dec;
    logic             capture;
    logic [3:0]       mask_q, mask_d, mask_next;
    logic [3:0][3:0]  digit_q, digit_d;
    logic             frame_done;
    logic [15:0]      value_q, value_d;
    logic             frame_valid_q;
    logic             seg_err_q, seg_err_d;
    logic             en_err_q, en_err_d;

    assign samp     = {sync2_q[10:4] ^ SegFlip, sync2_q[3:0] ^ EnFlip};
    assign samp_seg = samp[10:4];
    assign samp_en  = samp[3:0];
    assign changed  = (samp != samp_prev_q);

    // One accept per stable period: the flag stays set until the sample moves.
    assign accept   = !changed && (cnt_q == CntMax) && !accepted_q;
    assign en_one   = $onehot(samp_en);
    assign en_multi = (samp_en != 4'b0000) && !en_one;
    assign dec      = decode_seg(samp_seg);
    assign capture  = accept && en_one;

    always_comb begin
        en_idx = 2'd0;
        unique case (samp_en)
            4'b0001: en_idx = 2'd0;
            4'b0010: en_idx = 2'd1;
            4'b0100: en_idx = 2'd2;
            4'b1000: en_idx = 2'd3;
            default: en_idx = 2'd0;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        accepted_d = accepted_q;
        if (changed) begin
            cnt_d      = 8'd0;
            accepted_d = 1'b0;
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (accept) begin
                accepted_d = 1'b1;
            end
        end
    end

    always_comb begin
        digit_d   = digit_q;
        mask_next = mask_q | (4'b0001 << en_idx);
        mask_d    = mask_q;
        if (capture) begin
            digit_d[en_idx] = dec[3:0];
            mask_d          = mask_next;
        end
        frame_done = capture && (mask_next == 4'b1111);
        value_d    = value_q;
        if (frame_done) begin
            mask_d  = 4'b0000;
            value_d = digit_d;
        end
    end

    // A new error in the same cycle as clr_err takes priority.
    always_comb begin
        seg_err_d = bus.clr_err ? 1'b0 : seg_err_q;
        en_err_d  = bus.clr_err ? 1'b0 : en_err_q;
        if (capture && dec[4]) begin
            seg_err_d = 1'b1;
        end
        if (accept && en_multi) begin
            en_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            samp_prev_q   <= '0;
            cnt_q         <= '0;
            accepted_q    <= 1'b0;
            mask_q        <= '0;
            digit_q       <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            en_err_q      <= 1'b0;
        end else begin
            sync1_q       <= {bus.seven_seg, bus.digit_en};
            sync2_q       <= sync1_q;
            samp_prev_q   <= samp;
            cnt_q         <= cnt_d;
            accepted_q    <= accepted_d;
            mask_q        <= mask_d;
            digit_q       <= digit_d;
            value_q       <= value_d;
            frame_valid_q <= frame_done;
            seg_err_q     <= seg_err_d;
            en_err_q      <= en_err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.en_err      = en_err_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// Bench for seg_mux_capture: directed scans plus random holds, checked each cycle
// against a pin-level run-length model of the display receiver.
module tb_seg_mux_capture;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_mux_capture_if a_if ();
    seg_mux_capture_if b_if ();

    seg_mux_capture #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (a_if)
    );

    seg_mux_capture #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit sel = 1'b0;  // 0: active-high instance, 1: active-low instance
    int fv_seen = 0;

    // Model state: current pin pattern, how many edges it has been held, queued accept.
    logic [10:0] m_cur;
    int          m_run;
    bit          m_pend;
    logic [10:0] m_pend_p;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_mask;
    logic [15:0] m_value;
    bit          m_fv, m_seg_err, m_en_err;

    logic [15:0] o_value;
    logic        o_fv, o_seg_err, o_en_err;
    always_comb begin
        o_value   = sel ? b_if.value       : a_if.value;
        o_fv      = sel ? b_if.frame_valid : a_if.frame_valid;
        o_seg_err = sel ? b_if.seg_err     : a_if.seg_err;
        o_en_err  = sel ? b_if.en_err      : a_if.en_err;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h7E; 1: return 7'h30; 2: return 7'h6D; 3: return 7'h79;
            4: return 7'h33; 5: return 7'h5B; 6: return 7'h5F; 7: return 7'h70;
            8: return 7'h7F; 9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input logic [6:0] seg);
        for (int d = 0; d < 10; d++) begin
            if (seg == seg_of(d)) return 4'(d);
        end
        if (seg == 7'h00) return 4'hE;
        return 4'hF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_capture(input logic [10:0] p);
        logic [3:0] en;
        logic [6:0] seg;
        int         n;
        en  = p[3:0];
        seg = p[10:4];
        if (en == 4'b0000) return;
        if ($countones(en) > 1) begin
            m_en_err = 1'b1;
            return;
        end
        n = 0;
        for (int i = 0; i < 4; i++) if (en[i]) n = i;
        m_dig[n] = ref_code(seg);
        if (m_dig[n] == 4'hF) m_seg_err = 1'b1;
        m_mask[n] = 1'b1;
        if (m_mask == 4'hF) begin
            m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            m_fv    = 1'b1;
            m_mask  = 4'h0;
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] seg, input logic clr);
        if (sel) begin
            b_if.digit_en  = ~en;
            b_if.seven_seg = ~seg;
            b_if.clr_err   = clr;
            a_if.clr_err   = 1'b0;
        end else begin
            a_if.digit_en  = en;
            a_if.seven_seg = seg;
            a_if.clr_err   = clr;
            b_if.clr_err   = 1'b0;
        end
    endtask

    // One clock: set pins, advance the model, then compare all outputs after the edge.
    task automatic step(input logic [3:0] en, input logic [6:0] seg, input logic clr);
        logic [10:0] p, cap_p;
        bit          do_cap;
        p        = {seg, en};
        do_cap   = m_pend;
        cap_p    = m_pend_p;
        m_pend   = (m_run == S + 1);
        m_pend_p = m_cur;
        if (p != m_cur) begin
            m_cur = p;
            m_run = 0;
        end
        m_fv = 1'b0;
        if (clr) begin
            m_seg_err = 1'b0;
            m_en_err  = 1'b0;
        end
        if (do_cap) m_capture(cap_p);
        drive(en, seg, clr);
        @(posedge clk);
        #1;
        if (m_run < 255) m_run++;
        if (o_fv) fv_seen++;
        check("value", 32'(o_value), 32'(m_value));
        check("frame_valid", 32'(o_fv), 32'(m_fv));
        check("seg_err", 32'(o_seg_err), 32'(m_seg_err));
        check("en_err", 32'(o_en_err), 32'(m_en_err));
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int cycles);
        for (int i = 0; i < cycles; i++) step(en, seg, 1'b0);
    endtask

    task automatic scan_digit(input int pos, input logic [6:0] seg);
        hold(4'(1 << pos), seg, 8);
        hold(4'b0000, 7'h00, 2);
    endtask

    task automatic do_reset();
        a_if.digit_en = 4'h0; a_if.seven_seg = 7'h00; a_if.clr_err = 1'b0;
        b_if.digit_en = 4'hF; b_if.seven_seg = 7'h7F; b_if.clr_err = 1'b0;
        rst_n = 1'b0;
        m_cur = 11'h0; m_run = 0; m_pend = 1'b0; m_pend_p = 11'h0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_mask = 4'h0; m_value = 16'h0; m_fv = 1'b0; m_seg_err = 1'b0; m_en_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_value", 32'(o_value), 32'(m_value));
        check("rst_frame_valid", 32'(o_fv), 32'(m_fv));
        check("rst_seg_err", 32'(o_seg_err), 32'(m_seg_err));
        check("rst_en_err", 32'(o_en_err), 32'(m_en_err));
    endtask

    initial begin
        int fv0, lat;
        logic [3:0] ren;
        logic [6:0] rseg;
        int pos;

        // Scan "1234"
        do_reset();
        fv0 = fv_seen;
        scan_digit(0, 7'h33);
        scan_digit(1, 7'h79);
        scan_digit(2, 7'h6D);
        scan_digit(3, 7'h30);
        check("scan_value", 32'(o_value), 32'h1234);
        check("scan_frames", 32'(fv_seen - fv0), 32'd1);
        check("scan_seg_err", 32'(o_seg_err), 32'd0);

        // Latency: frame completes on the edge that captures digit 0
        do_reset();
        scan_digit(3, 7'h30);
        scan_digit(2, 7'h30);
        scan_digit(1, 7'h30);
        hold(4'b0000, 7'h00, 6);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(4'b0001, 7'h7E, 1'b0);
            if (o_fv && lat < 0) lat = i;
        end
        check("latency_edge", 32'(lat), 32'(S + 3));
        hold(4'b0000, 7'h00, 4);
        // Too-short hold must not capture
        fv0 = fv_seen;
        scan_digit(3, 7'h30);
        scan_digit(2, 7'h30);
        scan_digit(1, 7'h30);
        hold(4'b0001, 7'h7B, 3);
        hold(4'b0000, 7'h00, 10);
        check("short_hold_frames", 32'(fv_seen - fv0), 32'd0);

        // Glitch inside a hold
        do_reset();
        fv0 = fv_seen;
        scan_digit(3, 7'h30);
        scan_digit(2, 7'h6D);
        scan_digit(1, 7'h79);
        hold(4'b0001, 7'h5B, 2);
        hold(4'b0001, 7'h7F, 1);
        hold(4'b0001, 7'h5B, 6);
        hold(4'b0000, 7'h00, 10);
        check("glitch_frames", 32'(fv_seen - fv0), 32'd1);
        check("glitch_value", 32'(o_value), 32'h1235);
        check("glitch_seg_err", 32'(o_seg_err), 32'd0);

        // Error paths
        hold(4'b0011, 7'h30, 6);
        hold(4'b0000, 7'h00, 4);
        check("en_err_set", 32'(o_en_err), 32'd1);
        scan_digit(2, 7'h01);
        check("seg_err_set", 32'(o_seg_err), 32'd1);
        scan_digit(0, 7'h30);
        scan_digit(1, 7'h30);
        scan_digit(3, 7'h30);
        check("bad_digit_code", 32'(o_value[11:8]), 32'hF);
        step(4'b0000, 7'h00, 1'b1);
        check("clr_seg_err", 32'(o_seg_err), 32'd0);
        check("clr_en_err", 32'(o_en_err), 32'd0);

        // Reset mid-frame
        scan_digit(0, 7'h30);
        scan_digit(1, 7'h30);
        scan_digit(2, 7'h30);
        do_reset();
        fv0 = fv_seen;
        scan_digit(0, 7'h7E);
        scan_digit(1, 7'h7E);
        scan_digit(2, 7'h7E);
        check("midrst_no_early", 32'(fv_seen - fv0), 32'd0);
        scan_digit(3, 7'h7E);
        check("midrst_frames", 32'(fv_seen - fv0), 32'd1);
        check("midrst_value", 32'(o_value), 32'h0000);

        // Random holds against the model
        for (int k = 0; k < 120; k++) begin
            pos = int'($urandom_range(0, 3));
            rseg = ($urandom_range(0, 9) < 8) ? seg_of(int'($urandom_range(0, 10)))
                                              : 7'($urandom);
            case ($urandom_range(0, 19))
                0:       ren = 4'b0000;
                1:       ren = 4'b0101;
                default: ren = 4'(1 << pos);
            endcase
            for (int i = 0; i < int'($urandom_range(1, 9)); i++)
                step(ren, rseg, ($urandom_range(0, 29) == 0));
            hold(4'b0000, 7'h00, int'($urandom_range(0, 3)));
        end

        // Active-low instance: scan "9870", then a blank digit
        sel = 1'b1;
        do_reset();
        hold(4'b0000, 7'h00, 4);
        scan_digit(3, seg_of(9));
        scan_digit(2, seg_of(8));
        scan_digit(1, seg_of(7));
        scan_digit(0, seg_of(0));
        check("inv_value", 32'(o_value), 32'h9870);
        scan_digit(3, seg_of(9));
        scan_digit(2, seg_of(8));
        scan_digit(1, 7'h00);
        scan_digit(0, seg_of(0));
        check("inv_blank_digit", 32'(o_value), 32'h98E0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_mux_capture.md
Name: seg_mux_capture

Overview:
- Receive side of the multiplexed 7-segment display interface driven on the user IOs (7 segment lines plus 4 digit enables).
- Samples the segment and enable buses from io_in and filters out scan transitions and ghosting.
- Decodes each enabled digit's segment pattern back to a 4-bit code and reassembles a complete 4-digit frame.
- Used for loopback self-test of the timer display and for reading an external multiplexed display.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a digit is accepted. Legal range 2..255.
- SEG_ACTIVE_LOW, 0: 1 = segment lines are inverted at the input before decode.
- EN_ACTIVE_LOW, 0: 1 = digit enables are inverted at the input before decode.

Ports:
- clk  input  1  single clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- seven_seg  input  7  segment lines, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digit_en  input  4  digit enables, one-hot, bit0 = least-significant digit.
- clr_err  input  1  synchronous clear of the sticky error flags.
- value  output  16  last complete frame, digit n at bits [4n+3:4n].
- frame_valid  output  1  one-cycle pulse on the cycle value updates.
- seg_err  output  1  sticky: an unrecognised segment pattern was accepted.
- en_err  output  1  sticky: more than one enable was active in a stable sample.

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops, stability counter, digit registers, capture mask, value, frame_valid, seg_err and en_err all clear to 0. Reset mid-frame discards any partial frame.
- Input path: both buses pass through a 2-flop synchroniser, then the polarity inversions per the parameters. The result is the sample S (11 bits).
- Stability counter cnt (8 bits):
  - S != previous S: cnt <= 0 and the "accepted" flag clears.
  - Otherwise: cnt increments, saturating at STABLE_CYCLES-1.
- Accept event: S unchanged, cnt == STABLE_CYCLES-1 and accepted == 0. It sets accepted=1, so one stable period gives exactly one accept.
- Enable checks at accept:
  - Enables all zero (blanking gap): accept is ignored.
  - Two or more enables set: ignored, and en_err <= 1.
  - Exactly one enable set, index n: decode and capture digit n.
- Decode table (active-high pattern -> code):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 00 (blank) -> E.
  - Any other pattern -> F, and seg_err <= 1.
- Capture: digit_reg[n] <= code and mask[n] <= 1 on the edge after the accept condition.
- Latency: with the pins changing before edge 1 (the first sampling edge), digit_reg updates on edge STABLE_CYCLES+3.
- Recapture: re-accepting an already-masked digit before the frame completes overwrites digit_reg[n]. The mask is unchanged and no error is raised.
- Frame completion: on the edge the mask would become 4'b1111:
  - value <= all four digit codes, including the one being captured.
  - frame_valid <= 1 for exactly one cycle.
  - mask <= 0.
  - digit_reg keeps its contents.
- value holds its contents between frames.
- Sticky errors: seg_err and en_err clear only on clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the set wins.
- No output depends combinationally on any input. All outputs are registered.

Test Plan (STABLE_CYCLES=4, active-high unless stated):
- Scan "1234": each digit held 8 cycles with 2 blank cycles between. Sequence en=0001/seg=33, 0010/79, 0100/6D, 1000/30 -> value=16'h1234, frame_valid pulses once, no errors.
- Latency: apply en=0001/seg=7E from reset -> digit 0 capture appears on edge 7. Hold for 3 cycles then change -> no capture.
- Glitch: insert a 1-cycle seg=7F glitch inside an 8-cycle 5B hold -> digit captured as 5 exactly once, seg_err stays 0.
- Error paths: en=0011 held 6 cycles -> en_err=1, mask unchanged. seg=01 on digit 2 -> code F, seg_err=1. Pulse clr_err -> both flags 0.
- Polarity: SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, drive the inverted "9870" -> value=16'h9870. A blank digit reports E.
- Reset mid-frame: capture digits 0-2, assert rst_n low for 1 cycle, then scan "0000" -> value=0 and a single frame_valid only after all 4 new digits.
